// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter (core, DMA/loader) in front of a
// single-port synchronous data memory with one cycle of read latency.
//
// Configuration macro:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   -> contention is resolved round-robin
//                                         against the last granted requester.
//   DMEM_ARB_ROUND_ROBIN_EN  undefined -> core has fixed priority; a wait
//                                         counter forces a DMA grant after
//                                         MAX_WAIT-1 denied cycles.
//
// Grants are purely combinational in the request cycle. The arbiter never
// stores a request that was not granted; the only state is the read-return
// owner, the starvation counter (fixed mode) and the last grant (round-robin).

module dmem_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [3:0]        dma_be,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Who receives the memory read data on the cycle after a read grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t owner_q;
    owner_t owner_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Identity of the most recent grant; contention goes to the other side.
    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_DMA  = 1'b1
    } src_t;

    src_t last_gnt_q;
`else
    // Counter width covers 0..MAX_WAIT-1; a single bit is kept for MAX_WAIT=1.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] wait_cnt_q;
`endif

    // Combinational grant decision; at most one requester wins per cycle.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (core_req && dma_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (last_gnt_q == SRC_DMA) begin
                core_gnt = 1'b1;
            end else begin
                dma_gnt = 1'b1;
            end
`else
            if (wait_cnt_q == WAIT_LAST) begin
                dma_gnt = 1'b1;
            end else begin
                core_gnt = 1'b1;
            end
`endif
        end else if (core_req) begin
            core_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end
    end

    // Steer the granted bundle onto the memory port; reads enable all lanes.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        if (core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_be    = core_we ? core_be : 4'b1111;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dma_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_be    = dma_we ? dma_be : 4'b1111;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Next read-return owner: only a granted read claims the next data beat.
    always_comb begin
        owner_d = OWN_NONE;
        if (core_gnt && !core_we) begin
            owner_d = OWN_CORE;
        end else if (dma_gnt && !dma_we) begin
            owner_d = OWN_DMA;
        end
    end

    // Owner register; reset drops any read granted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Read return: only the owner sees rvalid and data, the other side sees 0.
    always_comb begin
        core_rvalid = 1'b0;
        core_rdata  = 32'h0000_0000;
        dma_rvalid  = 1'b0;
        dma_rdata   = 32'h0000_0000;
        case (owner_q)
            OWN_CORE: begin
                core_rvalid = 1'b1;
                core_rdata  = mem_rdata;
            end
            OWN_DMA: begin
                dma_rvalid = 1'b1;
                dma_rdata  = mem_rdata;
            end
            default: begin
                core_rvalid = 1'b0;
                dma_rvalid  = 1'b0;
            end
        endcase
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Remember the last winner; reset leaves it at DMA so core goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= SRC_DMA;
        end else if (core_gnt) begin
            last_gnt_q <= SRC_CORE;
        end else if (dma_gnt) begin
            last_gnt_q <= SRC_DMA;
        end
    end
`else
    // Count consecutive denied DMA cycles, saturating at the forcing value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (!dma_req || dma_gnt) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != WAIT_LAST) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with default parameters.
// Expectations adapt to DMEM_ARB_ROUND_ROBIN_EN when that macro is defined.

module tb_dmem_arbiter;

    localparam int ADDR_W = 18;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              core_req;
    logic              core_we;
    logic [3:0]        core_be;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [31:0]       core_rdata;
    logic              dma_req;
    logic              dma_we;
    logic [3:0]        dma_be;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int total;
    int bad;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_be      (dma_be),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then let logic settle.
    task automatic applyStimulus(
        input logic              r,
        input logic              creq,
        input logic              cwe,
        input logic [3:0]        cbe,
        input logic [ADDR_W-1:0] caddr,
        input logic [31:0]       cwd,
        input logic              dreq,
        input logic              dwe,
        input logic [3:0]        dbe,
        input logic [ADDR_W-1:0] daddr,
        input logic [31:0]       dwd,
        input logic [31:0]       mrd
    );
        @(negedge clk);
        rst        = r;
        core_req   = creq;
        core_we    = cwe;
        core_be    = cbe;
        core_addr  = caddr;
        core_wdata = cwd;
        dma_req    = dreq;
        dma_we     = dwe;
        dma_be     = dbe;
        dma_addr   = daddr;
        dma_wdata  = dwd;
        mem_rdata  = mrd;
        #1;
    endtask

    // Shorthand for an idle cycle with a chosen memory read-data value.
    task automatic idleCycle(input logic r, input logic [31:0] mrd);
        applyStimulus(r, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b0, 4'h0, '0, 32'h0, mrd);
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_be    = 4'h0;
        core_addr  = '0;
        core_wdata = 32'h0;
        dma_req    = 1'b0;
        dma_we     = 1'b0;
        dma_be     = 4'h0;
        dma_addr   = '0;
        dma_wdata  = 32'h0;
        mem_rdata  = 32'h0;

        // Reset for two cycles, then check the quiescent state.
        idleCycle(1'b1, 32'h0);
        idleCycle(1'b1, 32'h0);
        idleCycle(1'b0, 32'h0);
        checkOutput("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("rst_dma_rvalid",  32'(dma_rvalid),  32'd0);
        checkOutput("rst_mem_en",      32'(mem_en),      32'd0);

        // Idle for ten cycles: nothing enabled, no read returns.
        for (int i = 0; i < 10; i++) begin
            idleCycle(1'b0, 32'hA5A5_5A5A);
            checkOutput("idle_mem_en",      32'(mem_en),      32'd0);
            checkOutput("idle_mem_be",      32'(mem_be),      32'd0);
            checkOutput("idle_core_rvalid", 32'(core_rvalid), 32'd0);
            checkOutput("idle_dma_rvalid",  32'(dma_rvalid),  32'd0);
        end

        // Core-only read at 0x40, data returned the following cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 18'h00040, 32'h0,
                      1'b0, 1'b0, 4'h0, '0, 32'h0, 32'h0);
        checkOutput("crd_core_gnt", 32'(core_gnt), 32'd1);
        checkOutput("crd_dma_gnt",  32'(dma_gnt),  32'd0);
        checkOutput("crd_mem_en",   32'(mem_en),   32'd1);
        checkOutput("crd_mem_we",   32'(mem_we),   32'd0);
        checkOutput("crd_mem_be",   32'(mem_be),   32'hF);
        checkOutput("crd_mem_addr", 32'(mem_addr), 32'h40);
        idleCycle(1'b0, 32'hDEAD_BEEF);
        checkOutput("crd_core_rvalid", 32'(core_rvalid), 32'd1);
        checkOutput("crd_core_rdata",  core_rdata,       32'hDEAD_BEEF);
        checkOutput("crd_dma_rvalid",  32'(dma_rvalid),  32'd0);
        checkOutput("crd_dma_rdata",   dma_rdata,        32'h0);
        idleCycle(1'b0, 32'h1234_5678);
        checkOutput("crd_after_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("crd_after_rdata",  core_rdata,       32'h0);

        // DMA-only partial write at 0x100.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0,
                      1'b1, 1'b1, 4'b0011, 18'h00100, 32'h0000_ABCD, 32'h0);
        checkOutput("dwr_dma_gnt",   32'(dma_gnt),  32'd1);
        checkOutput("dwr_core_gnt",  32'(core_gnt), 32'd0);
        checkOutput("dwr_mem_we",    32'(mem_we),   32'd1);
        checkOutput("dwr_mem_be",    32'(mem_be),   32'b0011);
        checkOutput("dwr_mem_addr",  32'(mem_addr), 32'h100);
        checkOutput("dwr_mem_wdata", mem_wdata,     32'h0000_ABCD);
        idleCycle(1'b0, 32'hFFFF_FFFF);
        checkOutput("dwr_dma_rvalid",  32'(dma_rvalid),  32'd0);
        checkOutput("dwr_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("dwr_idle_addr",   32'(mem_addr),    32'd0);
        checkOutput("dwr_idle_wdata",  mem_wdata,        32'd0);

        // Back-to-back reads from alternating requesters, no bubbles.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h00010, 32'h0,
                      1'b0, 1'b0, 4'h0, '0, 32'h0, 32'h0);
        checkOutput("alt0_core_gnt", 32'(core_gnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, '0, 32'h0,
                      1'b1, 1'b0, 4'h0, 18'h00020, 32'h0, 32'h1111_1111);
        checkOutput("alt1_dma_gnt",     32'(dma_gnt),     32'd1);
        checkOutput("alt1_mem_addr",    32'(mem_addr),    32'h20);
        checkOutput("alt1_core_rvalid", 32'(core_rvalid), 32'd1);
        checkOutput("alt1_core_rdata",  core_rdata,       32'h1111_1111);
        checkOutput("alt1_dma_rdata",   dma_rdata,        32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h00030, 32'h0,
                      1'b0, 1'b0, 4'h0, '0, 32'h0, 32'h2222_2222);
        checkOutput("alt2_core_gnt",    32'(core_gnt),    32'd1);
        checkOutput("alt2_dma_rvalid",  32'(dma_rvalid),  32'd1);
        checkOutput("alt2_dma_rdata",   dma_rdata,        32'h2222_2222);
        checkOutput("alt2_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("alt2_core_rdata",  core_rdata,       32'h0);
        idleCycle(1'b0, 32'h3333_3333);
        checkOutput("alt3_core_rvalid", 32'(core_rvalid), 32'd1);
        checkOutput("alt3_core_rdata",  core_rdata,       32'h3333_3333);

        // Core write against DMA read in the same cycle; loser holds and follows.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b1100, 18'h00050, 32'hCAFE_0000,
                      1'b1, 1'b0, 4'h0, 18'h00060, 32'h0, 32'h0);
        checkOutput("mix0_core_gnt", 32'(core_gnt), 32'(!RR));
        checkOutput("mix0_dma_gnt",  32'(dma_gnt),  32'(RR));
        checkOutput("mix0_mem_we",   32'(mem_we),   32'(!RR));
        checkOutput("mix0_mem_addr", 32'(mem_addr), RR ? 32'h60 : 32'h50);
        applyStimulus(1'b0, RR, 1'b1, 4'b1100, 18'h00050, 32'hCAFE_0000,
                      !RR, 1'b0, 4'h0, 18'h00060, 32'h0, 32'h4444_4444);
        checkOutput("mix1_core_gnt",   32'(core_gnt),   32'(RR));
        checkOutput("mix1_dma_gnt",    32'(dma_gnt),    32'(!RR));
        checkOutput("mix1_dma_rvalid", 32'(dma_rvalid), 32'(RR));
        idleCycle(1'b0, 32'h5555_5555);
        checkOutput("mix2_dma_rvalid",  32'(dma_rvalid),  32'(!RR));
        checkOutput("mix2_core_rvalid", 32'(core_rvalid), 32'd0);

        // Core read granted while reset is asserted: grant visible, no return.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 18'h00070, 32'h0,
                      1'b0, 1'b0, 4'h0, '0, 32'h0, 32'h0);
        checkOutput("rstrd_core_gnt", 32'(core_gnt), 32'd1);
        idleCycle(1'b0, 32'h6666_6666);
        checkOutput("rstrd_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("rstrd_core_rdata",  core_rdata,       32'd0);

        // Continuous contention from a fresh reset state.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h00080, 32'h0,
                          1'b1, 1'b0, 4'h0, 18'h00090, 32'h0, 32'h7777_7777);
            if (RR) begin
                checkOutput("rr_core_gnt", 32'(core_gnt), 32'((i % 2) == 0));
                checkOutput("rr_dma_gnt",  32'(dma_gnt),  32'((i % 2) == 1));
                checkOutput("rr_dma_rvalid", 32'(dma_rvalid), 32'(i > 0 && (i % 2) == 0));
            end else begin
                checkOutput("fp_core_gnt", 32'(core_gnt), 32'((i % 8) != 7));
                checkOutput("fp_dma_gnt",  32'(dma_gnt),  32'((i % 8) == 7));
                checkOutput("fp_dma_rvalid", 32'(dma_rvalid), 32'(i > 0 && (i % 8) == 0));
            end
        end

        // Fixed mode: a cycle without a DMA request restarts the wait count.
        if (!RR) begin
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h000A0, 32'h0,
                              1'b1, 1'b0, 4'h0, 18'h000B0, 32'h0, 32'h0);
                checkOutput("clr_pre_core_gnt", 32'(core_gnt), 32'd1);
            end
            applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h000A0, 32'h0,
                          1'b0, 1'b0, 4'h0, '0, 32'h0, 32'h0);
            checkOutput("clr_gap_core_gnt", 32'(core_gnt), 32'd1);
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 18'h000A0, 32'h0,
                              1'b1, 1'b0, 4'h0, 18'h000B0, 32'h0, 32'h0);
                checkOutput("clr_dma_gnt", 32'(dma_gnt), 32'(i == 7));
            end
        end

        idleCycle(1'b0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18: word-memory byte-address width.
REQ-002 SHALL have parameter MAX_WAIT, default 8: cycles DMA may be denied before a forced grant (fixed-priority mode).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports core_req/core_we  in  1 each  core access request / write qualifier.
REQ-006 SHALL have ports core_be  in  4, core_addr  in  ADDR_W, core_wdata  in  32  core byte strobes, address, pre-shifted store data.
REQ-007 SHALL have ports core_gnt  out  1, core_rvalid  out  1, core_rdata  out  32  grant, read-return strobe, read data.
REQ-008 SHALL have ports dma_req/dma_we  in  1, dma_be  in  4, dma_addr  in  ADDR_W, dma_wdata  in  32  DMA/loader request bundle.
REQ-009 SHALL have ports dma_gnt  out  1, dma_rvalid  out  1, dma_rdata  out  32  DMA grant and read return.
REQ-010 SHALL have ports mem_en/mem_we  out  1, mem_be  out  4, mem_addr  out  ADDR_W, mem_wdata  out  32, mem_rdata  in  32  single-port synchronous memory, 1-cycle read latency.

Function
REQ-011 Grants SHALL be combinational in the request cycle; at most one of core_gnt/dma_gnt asserted per cycle.
REQ-012 Requester without contention SHALL be granted the same cycle it requests.
REQ-013 Requester SHALL hold its bundle stable until granted; arbiter SHALL not latch unaccepted requests.
REQ-014 Granted bundle SHALL drive mem_*; mem_en=1, mem_we=granted we, mem_be=granted be (mem_be forced 4'b1111 on reads).
REQ-015 No grant: mem_en=0, mem_we=0, mem_be=0, mem_addr/mem_wdata=0.
REQ-016 Granted read SHALL set owner register; next cycle exactly the owner's rvalid=1 and its rdata=mem_rdata.
REQ-017 Non-owner rdata SHALL be 0; rvalid SHALL be 0 after writes and idle cycles.
REQ-018 Back-to-back reads from alternating requesters SHALL each return in grant+1 with no bubbles.
REQ-019 Fixed priority: on contention core wins unless wait_cnt==MAX_WAIT-1, in which case DMA wins.
REQ-020 wait_cnt SHALL increment each cycle dma_req=1 and dma_gnt=0, clear on dma_gnt or dma_req=0, saturate at MAX_WAIT-1.
REQ-021 Core loses at most one cycle per forced DMA grant; counter SHALL restart from 0 after it.
REQ-022 Simultaneous write by one and read by other SHALL follow the same arbitration; no merging.

Reset
REQ-023 When rst=1 at a clock edge: owner cleared, core_rvalid=dma_rvalid=0, wait_cnt=0, last_gnt=DMA.
REQ-024 Read granted in the cycle rst asserts SHALL produce no rvalid in the following cycle.
REQ-025 Grants remain combinational during reset; requesters SHALL not rely on accesses during rst.

Configuration
REQ-026 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on contention grant the requester opposite last_gnt; last_gnt updates on every grant; wait_cnt held 0.
REQ-027 Macro undefined: fixed priority with starvation counter per REQ-019..REQ-021; last_gnt unused.

Verification
REQ-028 Core-only read addr 0x40, mem_rdata=0xDEADBEEF -> core_gnt same cycle, core_rvalid=1 and core_rdata=0xDEADBEEF next cycle, dma_rvalid=0.
REQ-029 DMA-only write addr 0x100, be=4'b0011, data 0x0000ABCD -> dma_gnt=1, mem_we=1, mem_be=0011, no rvalid next cycle.
REQ-030 Fixed mode, MAX_WAIT=8, both requesting continuously -> core granted 7 cycles, DMA granted 8th, pattern repeats.
REQ-031 Round-robin mode, both requesting reads continuously -> grants alternate core, DMA, ... starting with core after reset; rvalids alternate one cycle later.
REQ-032 Core read granted, rst=1 same cycle -> core_rvalid=0 next cycle, wait_cnt=0.
REQ-033 Idle 10 cycles -> mem_en=0, mem_be=0, both rvalid=0 throughout.
